// File: rtl/snn_pkg.sv
// Shared types and constants for the spike event encoder.
// Optional feature macro: SPIKE_EVENT_ENCODER_EMPTY_MARKER_EN (see spike_event_encoder.sv).
package snn_pkg;

  // Default neuron count and timestamp width
  localparam int NN   = 16;
  localparam int TS_W = 8;

  // Index width needed to address n neurons (at least one bit)
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int IW_DEF = idx_width(NN);

  // One address event as it appears on the stream
  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [IW_DEF-1:0] idx;
  } spike_event_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } enc_state_t;

endpackage

// File: rtl/spike_prio_enc.sv
// Combinational lowest-set-bit encoder over the active spike vector.
// idx is the lowest set bit, any flags a non-empty vector, onehot_last flags
// that exactly one bit remains.
module spike_prio_enc
  import snn_pkg::*;
#(
  parameter int N  = 16,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          onehot_last
);

  // Scan from the top down so the lowest set bit wins
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign any         = |vec;
  // Clearing the lowest set bit leaves zero only for a single-bit vector
  assign onehot_last = any && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/spike_event_encoder.sv
// Converts per-step spike vectors into an AXI-stream of address events
// {timestamp, neuron index}, lowest index first, with one pending slot so a
// slow consumer does not stall the neuron array.
// Optional feature macro: SPIKE_EVENT_ENCODER_EMPTY_MARKER_EN -- when defined,
// a zero-spike step emits a single marker beat (idx 0, m_tuser=1, m_tlast=1).
module spike_event_encoder
  import snn_pkg::*;
#(
  parameter int N   = 16,
  parameter int TSW = 8,
  parameter int DCW = 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [N-1:0]              spike_in,
  input  logic                      time_step,
  output logic [TSW+$clog2(N)-1:0]  m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast,
  output logic                      m_tuser,
  output logic                      overflow,
  output logic [DCW-1:0]            drop_count,
  output logic                      busy
);

  localparam int IW = $clog2(N);

  enc_state_t     state_reg, state_next;
  logic [N-1:0]   act_vec_reg, act_vec_next;
  logic [TSW-1:0] act_ts_reg, act_ts_next;
  logic           act_mark_reg, act_mark_next;
  logic           pend_valid_reg, pend_valid_next;
  logic [N-1:0]   pend_vec_reg, pend_vec_next;
  logic [TSW-1:0] pend_ts_reg, pend_ts_next;
  logic           pend_mark_reg, pend_mark_next;
  logic [TSW-1:0] ts_reg;
  logic           overflow_reg;
  logic [DCW-1:0] drop_cnt_reg;
  logic           drop;

  logic [IW-1:0]  enc_idx;
  logic           enc_any;
  logic           enc_last;

  logic           cap;
  logic [N-1:0]   cap_vec;
  logic           cap_mark;
  logic           hs;
  logic           fin;

`ifdef SPIKE_EVENT_ENCODER_EMPTY_MARKER_EN
  // Every step is captured; an empty step is carried as bit 0 plus a marker
  // flag so the normal drain path emits exactly one beat with index 0.
  assign cap      = time_step;
  assign cap_vec  = (|spike_in) ? spike_in : N'(1);
  assign cap_mark = ~(|spike_in);
`else
  // Empty steps are skipped entirely; the marker flag is never set.
  assign cap      = time_step & (|spike_in);
  assign cap_vec  = spike_in;
  assign cap_mark = 1'b0;
`endif

  spike_prio_enc #(
    .N  (N),
    .IW (IW)
  ) u_prio_enc (
    .vec         (act_vec_reg),
    .idx         (enc_idx),
    .any         (enc_any),
    .onehot_last (enc_last)
  );

  assign m_tvalid   = (state_reg == DRAIN) & enc_any;
  assign m_tdata    = {act_ts_reg, enc_idx};
  assign m_tlast    = m_tvalid & enc_last;
  assign m_tuser    = m_tvalid & act_mark_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_cnt_reg;
  assign busy       = m_tvalid | pend_valid_reg;

  assign hs  = m_tvalid & m_tready;
  assign fin = hs & enc_last;

  // Next-state: slot loading, bit clearing on handshake, pending promotion and drops
  always_comb begin
    state_next      = state_reg;
    act_vec_next    = act_vec_reg;
    act_ts_next     = act_ts_reg;
    act_mark_next   = act_mark_reg;
    pend_valid_next = pend_valid_reg;
    pend_vec_next   = pend_vec_reg;
    pend_ts_next    = pend_ts_reg;
    pend_mark_next  = pend_mark_reg;
    drop            = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cap) begin
          act_vec_next  = cap_vec;
          act_ts_next   = ts_reg;
          act_mark_next = cap_mark;
          state_next    = DRAIN;
        end
      end
      DRAIN: begin
        if (hs) act_vec_next = act_vec_reg & (act_vec_reg - N'(1));
        if (fin) begin
          if (pend_valid_reg) begin
            // Promote pending; a coincident new step takes its place
            act_vec_next  = pend_vec_reg;
            act_ts_next   = pend_ts_reg;
            act_mark_next = pend_mark_reg;
            if (cap) begin
              pend_vec_next  = cap_vec;
              pend_ts_next   = ts_reg;
              pend_mark_next = cap_mark;
            end else begin
              pend_valid_next = 1'b0;
            end
          end else if (cap) begin
            // Load straight into active so there is no idle bubble
            act_vec_next  = cap_vec;
            act_ts_next   = ts_reg;
            act_mark_next = cap_mark;
          end else begin
            state_next = IDLE;
          end
        end else if (cap) begin
          if (!pend_valid_reg) begin
            pend_valid_next = 1'b1;
            pend_vec_next   = cap_vec;
            pend_ts_next    = ts_reg;
            pend_mark_next  = cap_mark;
          end else begin
            drop = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, slot, timestamp and drop-statistics registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg      <= IDLE;
      act_vec_reg    <= '0;
      act_ts_reg     <= '0;
      act_mark_reg   <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_vec_reg   <= '0;
      pend_ts_reg    <= '0;
      pend_mark_reg  <= 1'b0;
      ts_reg         <= '0;
      overflow_reg   <= 1'b0;
      drop_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      act_vec_reg    <= act_vec_next;
      act_ts_reg     <= act_ts_next;
      act_mark_reg   <= act_mark_next;
      pend_valid_reg <= pend_valid_next;
      pend_vec_reg   <= pend_vec_next;
      pend_ts_reg    <= pend_ts_next;
      pend_mark_reg  <= pend_mark_next;
      // Timestamp advances on every step, captured, skipped or dropped
      if (time_step) ts_reg <= ts_reg + TSW'(1);
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + DCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed, table-driven bench for spike_event_encoder (N=16, TSW=8, DCW=8).
module tb_spike_event_encoder;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] spike_in = '0;
  logic        time_step = 1'b0;
  logic [11:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        m_tuser;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        busy;

  spike_event_encoder #(.N(16), .TSW(8), .DCW(8)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .spike_in   (spike_in),
    .time_step  (time_step),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .m_tuser    (m_tuser),
    .overflow   (overflow),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [7:0] ts;
    logic [3:0] idx;
    logic       last;
    logic       user;
  } beat_t;

  typedef struct {
    logic [15:0] vec;
    int          nb;
    int          first_idx;
    int          last_idx;
    logic        user;
  } vec_t;

  beat_t      got[$];
  vec_t       tbl[6];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] ts_model = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int nth_set(input logic [15:0] v, input int n);
    int k = 0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        if (k == n) return i;
        k++;
      end
    end
    return 0;
  endfunction

  // One time_step pulse; returns at the negedge after the capturing edge
  task automatic step(input logic [15:0] v);
    spike_in  = v;
    time_step = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    time_step = 1'b0;
    spike_in  = '0;
    ts_model  = ts_model + 8'd1;
  endtask

  // Consume beats for n cycles; toggle gives ready 1,0,1,0...
  task automatic run_cycles(input int n, input bit toggle);
    logic        stalled = 1'b0;
    logic [11:0] held = '0;
    logic        held_last = 1'b0;
    beat_t       b;
    for (int c = 0; c < n; c++) begin
      m_tready = toggle ? (c % 2 == 0) : 1'b1;
      if (stalled) begin
        chk("stall_valid", {31'd0, m_tvalid}, 32'd1);
        chk("stall_data", {19'd0, m_tdata, m_tlast}, {19'd0, held, held_last});
      end
      stalled = 1'b0;
      if (m_tvalid && m_tready) begin
        b = {m_tdata[11:4], m_tdata[3:0], m_tlast, m_tuser};
        got.push_back(b);
        $display("beat ts=%0d idx=%0d last=%0b user=%0b", b.ts, b.idx, b.last, b.user);
      end else if (m_tvalid) begin
        stalled   = 1'b1;
        held      = m_tdata;
        held_last = m_tlast;
      end
      @(posedge aclk);
      @(negedge aclk);
    end
    m_tready = 1'b0;
  endtask

  initial begin
    logic [7:0] ts_exp;
    tbl[0] = '{16'h8005, 3, 0, 15, 1'b0};
    tbl[1] = '{16'h0001, 1, 0, 0, 1'b0};
    tbl[2] = '{16'hFFFF, 16, 0, 15, 1'b0};
    tbl[3] = '{16'h4000, 1, 14, 14, 1'b0};
    tbl[4] = '{16'h0180, 2, 7, 8, 1'b0};
`ifdef SPIKE_EVENT_ENCODER_EMPTY_MARKER_EN
    tbl[5] = '{16'h0000, 1, 0, 0, 1'b1};
`else
    tbl[5] = '{16'h0000, 0, 0, 0, 1'b0};
`endif

    // Reset state
    #2;
    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_tdata", {20'd0, m_tdata}, 32'd0);
    chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
    chk("rst_tuser", {31'd0, m_tuser}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_drop_count", {24'd0, drop_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    // Backpressure: two steps held, third dropped
    m_tready = 1'b0;
    step(16'h0001);
    chk("bp_first_valid", {31'd0, m_tvalid}, 32'd1);
    chk("bp_first_data", {20'd0, m_tdata}, {20'd0, 8'd0, 4'd0});
    step(16'h0002);
    step(16'h0004);
    $display("backpressure: 3 steps issued, overflow=%0b drops=%0d", overflow, drop_count);
    chk("bp_overflow", {31'd0, overflow}, 32'd1);
    chk("bp_drop_count", {24'd0, drop_count}, 32'd1);
    chk("bp_busy", {31'd0, busy}, 32'd1);
    chk("bp_held_data", {20'd0, m_tdata}, {20'd0, 8'd0, 4'd0});
    got.delete();
    run_cycles(8, 1'b0);
    chk("bp_beats", got.size(), 32'd2);
    if (got.size() == 2) begin
      chk("bp_beat0", {18'd0, got[0]}, {18'd0, 8'd0, 4'd0, 1'b1, 1'b0});
      chk("bp_beat1", {18'd0, got[1]}, {18'd0, 8'd1, 4'd1, 1'b1, 1'b0});
    end
    chk("bp_busy_after", {31'd0, busy}, 32'd0);
    chk("bp_overflow_sticky", {31'd0, overflow}, 32'd1);

    // Toggling ready: same three beats, stable while stalled
    ts_exp = ts_model;
    step(16'h8005);
    got.delete();
    run_cycles(12, 1'b1);
    chk("tog_beats", got.size(), 32'd3);
    if (got.size() == 3) begin
      chk("tog_beat0", {18'd0, got[0]}, {18'd0, ts_exp, 4'd0, 1'b0, 1'b0});
      chk("tog_beat1", {18'd0, got[1]}, {18'd0, ts_exp, 4'd2, 1'b0, 1'b0});
      chk("tog_beat2", {18'd0, got[2]}, {18'd0, ts_exp, 4'd15, 1'b1, 1'b0});
    end

    // Table of single steps with ready held high
    for (int t = 0; t < 6; t++) begin
      ts_exp = ts_model;
      step(tbl[t].vec);
      $display("vector %0d: spikes=%h ts=%0d", t, tbl[t].vec, ts_exp);
      chk("tbl_latency", {31'd0, m_tvalid}, (tbl[t].nb > 0) ? 32'd1 : 32'd0);
      got.delete();
      run_cycles(20, 1'b0);
      chk("tbl_beats", got.size(), tbl[t].nb);
      if (got.size() == tbl[t].nb && tbl[t].nb > 0) begin
        chk("tbl_first_idx", {28'd0, got[0].idx}, tbl[t].first_idx);
        chk("tbl_last_idx", {28'd0, got[tbl[t].nb-1].idx}, tbl[t].last_idx);
        for (int i = 0; i < tbl[t].nb; i++) begin
          chk("tbl_ts", {24'd0, got[i].ts}, {24'd0, ts_exp});
          chk("tbl_idx", {28'd0, got[i].idx}, nth_set(tbl[t].vec, i));
          chk("tbl_last", {31'd0, got[i].last}, (i == tbl[t].nb - 1) ? 32'd1 : 32'd0);
          chk("tbl_user", {31'd0, got[i].user}, {31'd0, tbl[t].user});
        end
      end
      chk("tbl_busy_after", {31'd0, busy}, 32'd0);
    end

    // Reset asserted mid-drain
    m_tready = 1'b0;
    step(16'h00F0);
    chk("arst_pre_valid", {31'd0, m_tvalid}, 32'd1);
    #3;
    aresetn = 1'b0;
    #1;
    $display("async reset asserted mid-drain");
    chk("arst_valid", {31'd0, m_tvalid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_overflow", {31'd0, overflow}, 32'd0);
    chk("arst_drop_count", {24'd0, drop_count}, 32'd0);
    chk("arst_tdata", {20'd0, m_tdata}, 32'd0);
    @(negedge aclk);
    aresetn  = 1'b1;
    ts_model = '0;
    @(negedge aclk);

    // New step coincident with the final handshake: no idle bubble
    m_tready = 1'b1;
    step(16'h0003);
    chk("coin_beat0", {19'd0, m_tdata, m_tlast}, {19'd0, 8'd0, 4'd0, 1'b0});
    @(posedge aclk);
    @(negedge aclk);
    chk("coin_beat1", {19'd0, m_tdata, m_tlast}, {19'd0, 8'd0, 4'd1, 1'b1});
    spike_in  = 16'h0008;
    time_step = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    time_step = 1'b0;
    spike_in  = '0;
    ts_model  = ts_model + 8'd1;
    $display("coincident step: tvalid=%0b tdata=%h", m_tvalid, m_tdata);
    chk("coin_next_valid", {31'd0, m_tvalid}, 32'd1);
    chk("coin_next_beat", {19'd0, m_tdata, m_tlast}, {19'd0, 8'd1, 4'd3, 1'b1});
    @(posedge aclk);
    @(negedge aclk);
    chk("coin_idle", {31'd0, m_tvalid}, 32'd0);

    // 300 back-to-back single-spike steps: timestamp wraps
    m_tready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ts_exp = ts_model;
      step(16'd1 << (i % 16));
      $display("wrap step %0d: tdata=%h", i, m_tdata);
      chk("wrap_valid", {31'd0, m_tvalid}, 32'd1);
      chk("wrap_data", {20'd0, m_tdata}, {20'd0, ts_exp, 4'(i % 16)});
    end
    @(posedge aclk);
    @(negedge aclk);
    chk("wrap_idle", {31'd0, m_tvalid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
